// File: rtl/shift_seq_pkg.sv
// -----------------------------------------------------------------------------
// shift_seq_pkg
// Shared definitions for the shift-register sequencer:
//   state_t      - sequencer states (IDLE, LOAD, SHIFT, DONE)
//   FILL_*       - fill-source codes for the bit shifted into the LSB
//   fill_bit()   - selects the serial fill bit for a given fill code
// Optional feature macro used by the sequencer: SHIFT_SEQ_ABORT_EN.
// -----------------------------------------------------------------------------
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] FILL_ZERO = 2'b00;
  localparam logic [1:0] FILL_ONE  = 2'b01;
  localparam logic [1:0] FILL_SI   = 2'b10;
  localparam logic [1:0] FILL_ROT  = 2'b11;

  // Serial fill bit for the selected fill mode. ROT feeds back the MSB so
  // WIDTH shifts reproduce the original register value.
  function automatic logic fill_bit(input logic [1:0] mode,
                                    input logic       si,
                                    input logic       q_msb);
    logic b;
    case (mode)
      FILL_ZERO: b = 1'b0;
      FILL_ONE:  b = 1'b1;
      FILL_SI:   b = si;
      default:   b = q_msb;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/shift_seq_cnt.sv
// -----------------------------------------------------------------------------
// shift_seq_cnt
// Loadable saturating down-counter holding the remaining shift count.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   clr         - force value to 0 (highest priority)
//   load        - load load_val
//   load_val    - value to load
//   dec         - decrement by one; holds at 0 instead of wrapping
//   value       - current count
//   zero        - value == 0
// -----------------------------------------------------------------------------
module shift_seq_cnt
  import shift_seq_pkg::*;
#(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] value,
  output logic             zero
);

  logic [CNT_W-1:0] value_reg;
  logic [CNT_W-1:0] value_next;

  assign zero  = (value_reg == '0);
  assign value = value_reg;

  always_comb begin
    value_next = value_reg;
    if (clr) begin
      value_next = '0;
    end else if (load) begin
      value_next = load_val;
    end else if (dec && !zero) begin
      value_next = value_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_reg <= '0;
    end else begin
      value_reg <= value_next;
    end
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// -----------------------------------------------------------------------------
// shift_seq_ctrl
// Sequencer for a WIDTH-bit left-shift register: optional parallel load cycle
// followed by N single-bit left shifts with a selectable fill bit.
// start/busy/done handshake; start is only accepted in IDLE.
// Ports:
//   clk, rst_n       - clock, asynchronous active-low reset
//   start            - request pulse (sampled in IDLE only)
//   load_en          - perform a load cycle before shifting (sampled with start)
//   count            - number of shifts, clamped to WIDTH (sampled with start)
//   fill             - fill source code, see shift_seq_pkg (sampled with start)
//   si               - external serial bit (fill = FILL_SI)
//   q_msb            - register MSB feedback (fill = FILL_ROT)
//   reg_we           - register write enable
//   reg_sl           - 1 = shift, 0 = parallel load
//   reg_slin         - serial fill bit, 0 outside SHIFT
//   busy             - high in LOAD and SHIFT
//   done             - one-cycle completion pulse
//   remain           - shifts still to perform
// Optional (macro SHIFT_SEQ_ABORT_EN):
//   abort            - in LOAD/SHIFT, jump to DONE without further writes
//   aborted          - asserted together with done after an abort
// -----------------------------------------------------------------------------
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             load_en,
  input  logic [CNT_W-1:0] count,
  input  logic [1:0]       fill,
  input  logic             si,
  input  logic             q_msb,
`ifdef SHIFT_SEQ_ABORT_EN
  input  logic             abort,
`endif
  output logic             reg_we,
  output logic             reg_sl,
  output logic             reg_slin,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] remain
`ifdef SHIFT_SEQ_ABORT_EN
  ,
  output logic             aborted
`endif
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(WIDTH);

  state_t           state_reg;
  state_t           state_next;
  logic [1:0]       fill_reg;
  logic [1:0]       fill_next;
  logic [CNT_W-1:0] cnt_clamped;
  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_clr;
  logic             cnt_zero;
  logic [CNT_W-1:0] cnt_value;
  logic             abort_hit;

`ifdef SHIFT_SEQ_ABORT_EN
  logic aborted_reg;
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  assign cnt_clamped = (count > MAX_CNT) ? MAX_CNT : count;

  // The counter is loaded on the start cycle so remain already shows the
  // clamped count in the first LOAD/SHIFT cycle, and it is cleared in DONE
  // (and on abort) so it reads 0 in DONE and IDLE.
  shift_seq_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (cnt_clamped),
    .dec      (cnt_dec),
    .value    (cnt_value),
    .zero     (cnt_zero)
  );

  // Next-state and counter control
  always_comb begin
    state_next = state_reg;
    fill_next  = fill_reg;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    cnt_clr    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          fill_next = fill;
          cnt_load  = 1'b1;
          if (load_en) begin
            state_next = LOAD;
          end else if (cnt_clamped != '0) begin
            state_next = SHIFT;
          end else begin
            state_next = DONE;
          end
        end
      end
      LOAD: begin
        if (abort_hit) begin
          state_next = DONE;
          cnt_clr    = 1'b1;
        end else if (cnt_zero) begin
          state_next = DONE;
        end else begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        cnt_dec = 1'b1;
        if (abort_hit) begin
          state_next = DONE;
          cnt_clr    = 1'b1;
        end else if (cnt_value == CNT_W'(1)) begin
          // Last shift: the decrement lands on 0 as we enter DONE.
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
        cnt_clr    = 1'b1;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      fill_reg  <= FILL_ZERO;
    end else begin
      state_reg <= state_next;
      fill_reg  <= fill_next;
    end
  end

`ifdef SHIFT_SEQ_ABORT_EN
  // Set only on the transition into DONE caused by an abort, so it is high
  // exactly in that DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aborted_reg <= 1'b0;
    end else begin
      aborted_reg <= abort && ((state_reg == LOAD) || (state_reg == SHIFT));
    end
  end
  assign aborted = aborted_reg;
`endif

  // Moore outputs; reg_slin is the only combinational path from live inputs.
  always_comb begin
    reg_we   = 1'b0;
    reg_sl   = 1'b0;
    reg_slin = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_reg)
      LOAD: begin
        reg_we = 1'b1;
        busy   = 1'b1;
      end
      SHIFT: begin
        reg_we   = 1'b1;
        reg_sl   = 1'b1;
        reg_slin = fill_bit(fill_reg, si, q_msb);
        busy     = 1'b1;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign remain = cnt_value;

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
Sequencer for the 16-bit left-shift register. It drives the register's `we`, `sl` and `slin` controls to run an optional parallel load followed by N single-bit left shifts, with a selectable fill source (0, 1, external serial bit, or rotate of the MSB). It sits between the microsequencer and the shift register and serves the multi-bit shift, rotate and multiply/divide step instructions. It uses a start/busy/done handshake.

Parameters:
- WIDTH, 16, width of the controlled shift register; sets the maximum legal shift count.
- CNT_W, 5, width of the shift-count input and the remaining-count output; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; accepted only in IDLE.
- load_en  input  1  sampled with start; 1 = perform a parallel load cycle before shifting.
- count  input  CNT_W  sampled with start; number of shifts, values above WIDTH saturate to WIDTH.
- fill  input  2  sampled with start; 00 = zero, 01 = one, 10 = serial input si, 11 = rotate (q_msb).
- si  input  1  external serial bit; used combinationally during SHIFT when fill = 10.
- q_msb  input  1  q[WIDTH-1] fed back from the shift register; used when fill = 11.
- reg_we  output  1  register write enable.
- reg_sl  output  1  register shift select (1 = shift, 0 = parallel load).
- reg_slin  output  1  serial fill bit to the register.
- busy  output  1  high in LOAD and SHIFT.
- done  output  1  single-cycle completion pulse.
- remain  output  CNT_W  shifts still to perform.

Behaviour:
- Reset: clk and rst_n as above; reset is asynchronous and active-low. All outputs are 0, state is IDLE, and the latched count, fill and load_en are 0.
- State machine:
  - IDLE: when start is seen, latch cnt = min(count, WIDTH), fill and load_en. Go to LOAD if load_en. Otherwise go to SHIFT if cnt ≠ 0, else DONE.
  - LOAD: lasts one cycle, with reg_we = 1 and reg_sl = 0. Next state is SHIFT if cnt ≠ 0, else DONE.
  - SHIFT: reg_we = 1 and reg_sl = 1 every cycle. remain decrements by 1 per cycle. When remain = 1 the next state is DONE, so exactly cnt shift cycles occur.
  - DONE: lasts one cycle with done = 1, then returns to IDLE.
- Outputs are Moore-decoded from registered state, except reg_slin. reg_slin is combinational from the latched fill and the live si/q_msb inputs, and is 0 outside SHIFT.
- remain equals cnt on entry to LOAD or SHIFT, counts down to 1 during SHIFT, and is 0 in DONE and IDLE.
- Latency from the start cycle T:
  - First control cycle is T+1.
  - done is asserted at T + 1 + load_en + cnt.
  - A new start is accepted at the earliest one cycle after done.
- Boundary cases:
  - start is ignored while busy or done is high; no queuing.
  - count = 0 with load_en = 0 gives a DONE pulse only, with no reg_we.
  - count ≥ WIDTH is clamped to WIDTH; a full rotate returns the original value.
  - rst_n low mid-operation returns to IDLE immediately and forces reg_we low. The register contents are whatever had been written so far.
  - Changes on count, fill or load_en after the start cycle have no effect.

Optional Feature:
- Macro: SHIFT_SEQ_ABORT_EN.
- With the macro defined, an extra input `abort` (1 bit) is present. Asserting abort in LOAD or SHIFT forces the next state to DONE: no further reg_we, remain reads 0 in DONE, and an extra output `aborted` is asserted alongside done. abort in IDLE or DONE is ignored.
- Without the macro, neither port exists and sequences always run to completion.

Decomposition:
- Shared package shift_seq_pkg holds:
  - the state encoding constants (IDLE, LOAD, SHIFT, DONE);
  - the fill-mode constants FILL_ZERO, FILL_ONE, FILL_SI, FILL_ROT.
- One natural sub-module, shift_seq_cnt: a loadable saturating down-counter with load, dec and zero-flag outputs, instantiated for remain.

Test Plan:
- Load then shift with zero fill: load_en = 1, count = 3, fill = 00, register d = 0x1234. Expect 1 load cycle and 3 shift cycles, register = 0x91A0, done at T+5.
- Rotate: load_en = 1, count = 4, fill = 11, d = 0x8001. Expect register = 0x0018; with count = 16 the register returns 0x8001.
- Shift-only serial fill: load_en = 0, count = 2, fill = 10, si driven 1 then 0, starting register 0x0000. Expect register = 0x0002 and done at T+3.
- Zero count and saturation: count = 0, load_en = 0 gives a done pulse at T+1 with reg_we never high. count = 31 produces exactly 16 shift cycles.
- Handshake: start pulses during busy and during the done cycle are ignored. start asserted one cycle after done is accepted.
- Reset mid-shift: rst_n low during the 2nd of 5 shifts sets all outputs to 0 immediately. After release the block is in IDLE and accepts a new start.
